pid_mul_sequencer: RTL

PID_MUL_SEQUENCER -- requirements
Module: pid_mul_sequencer

---
 rtl/pid_mul_sequencer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/pid_mul_sequencer.sv
// Sequences the three PID products (kp*e, ki*i, kd*d) through one shared serial
// multiplier, accumulates them, then saturates (acc >>> SHIFT) to N bits.
// Optional multiplier watchdog: define PID_SEQ_TIMEOUT_EN.
module pid_mul_sequencer #(
  parameter int N              = 4,
  parameter int SHIFT          = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_strb_i,
  input  logic signed [N-1:0]   kp_i,
  input  logic signed [N-1:0]   ki_i,
  input  logic signed [N-1:0]   kd_i,
  input  logic signed [N-1:0]   e_i,
  input  logic signed [N-1:0]   i_i,
  input  logic signed [N-1:0]   d_i,
  output logic                  busy_o,
  output logic                  done_strb_o,
  output logic signed [2*N+1:0] acc_o,
  output logic signed [N-1:0]   sat_o,
  output logic                  error_o,
  output logic                  mul_start_strb_o,
  output logic signed [N-1:0]   mul_a_o,
  output logic signed [N-1:0]   mul_b_o,
  input  logic                  mul_done_strb_i,
  input  logic signed [2*N-1:0] mul_out_i
);

  localparam int ACC_W = 2*N + 2;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(N-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                   state, state_next;
  logic [1:0]               idx;
  logic [ACC_W-1:0]         acc;
  logic signed [N-1:0]      kp_q, ki_q, kd_q, e_q, i_q, d_q;

  logic                     start_accept;
  logic                     mul_accept;
  logic [ACC_W-1:0]         acc_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [N-1:0]      sat_next;

`ifdef PID_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             error_q;
`endif

  // Next-state and per-cycle control decode.
  // NOTE: every signal assigned here gets a default first so no path infers a latch.
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    mul_accept   = 1'b0;
`ifdef PID_SEQ_TIMEOUT_EN
    timeout_hit  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start_strb_i) begin
          start_accept = 1'b1;
          state_next   = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (mul_done_strb_i) begin
          mul_accept = 1'b1;
          state_next = (idx == 2'd2) ? S_DONE : S_ISSUE;
        end
`ifdef PID_SEQ_TIMEOUT_EN
        else if (wait_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = S_IDLE;
        end
`endif
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Accumulate the sign-extended product and saturate the shifted sum.
  always_comb begin
    acc_sum = acc + {{2{mul_out_i[2*N-1]}}, mul_out_i};
    shifted = $signed(acc_sum) >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat_next = SAT_MAX[N-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_next = SAT_MIN[N-1:0];
    end else begin
      sat_next = shifted[N-1:0];
    end
  end

  // Operand mux for the shared multiplier; quiet outside ISSUE/WAIT.
  always_comb begin
    mul_a_o = '0;
    mul_b_o = '0;
    if (state == S_ISSUE || state == S_WAIT) begin
      case (idx)
        2'd0:    begin mul_a_o = kp_q; mul_b_o = e_q; end
        2'd1:    begin mul_a_o = ki_q; mul_b_o = i_q; end
        default: begin mul_a_o = kd_q; mul_b_o = d_q; end
      endcase
    end
  end

  assign busy_o           = (state != S_IDLE);
  assign done_strb_o      = (state == S_DONE);
  assign mul_start_strb_o = (state == S_ISSUE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      idx   <= '0;
      acc   <= '0;
      acc_o <= '0;
      sat_o <= '0;
      // NOTE: the snapshot registers are cleared too, so nothing from an aborted
      // computation can leak out on mul_a_o/mul_b_o afterwards.
      kp_q  <= '0;
      ki_q  <= '0;
      kd_q  <= '0;
      e_q   <= '0;
      i_q   <= '0;
      d_q   <= '0;
    end else begin
      state <= state_next;
      if (start_accept) begin
        kp_q <= kp_i;
        ki_q <= ki_i;
        kd_q <= kd_i;
        e_q  <= e_i;
        i_q  <= i_i;
        d_q  <= d_i;
        acc  <= '0;
        idx  <= '0;
      end
      if (mul_accept) begin
        acc <= acc_sum;
        if (idx != 2'd2) begin
          idx <= idx + 2'd1;
        end else begin
          // Results are published on entry to DONE so they are valid with done_strb_o.
          acc_o <= $signed(acc_sum);
          sat_o <= sat_next;
        end
      end
    end
  end

`ifdef PID_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (start_accept) begin
        error_q <= 1'b0;
      end else if (timeout_hit) begin
        error_q <= 1'b1;
      end
    end
  end

  assign error_o = error_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYCLES > 0);
  assign error_o        = 1'b0;
`endif

endmodule
